// File: rtl/regfile_scoreboard_pkg.sv
// Shared types and helpers for the multi-issue register file and scoreboard.
// Lane fields travel as packed vectors; lane_slice pulls one lane out.
package pap_pkg;

  localparam int XLEN_D  = 32;
  localparam int NREGS_D = 32;
  localparam int AW_D    = $clog2(NREGS_D);
  localparam int LANES_MAX = 4;

  typedef logic [AW_D-1:0] reg_addr_t;
  typedef logic [$clog2(LANES_MAX)-1:0] lane_idx_t;

  function automatic logic [63:0] lane_slice(
    input logic [255:0] v,
    input int           i,
    input int           w
  );
    logic [63:0] m;
    m = (64'(1) << w) - 64'(1);
    return 64'(v >> (i * w)) & m;
  endfunction

endpackage

// File: rtl/regfile_scoreboard_if.sv
// Issue/writeback bus between decode and the register file + scoreboard.
// master = decode side, slave = register file.
interface regfile_scoreboard_if #(
  parameter int LANES = 2,
  parameter int XLEN  = 32,
  parameter int AW    = 5
);

  logic [LANES-1:0]      issue_req;
  logic [LANES*AW-1:0]   src_a;
  logic [LANES*AW-1:0]   src_b;
  logic [LANES*AW-1:0]   dst;
  logic [LANES-1:0]      wb_we;
  logic [LANES*AW-1:0]   wb_addr;
  logic [LANES*XLEN-1:0] wb_data;
  logic                  flush;
  logic [LANES-1:0]      grant;
  logic [LANES-1:0]      op_valid;
  logic [LANES*XLEN-1:0] op_a;
  logic [LANES*XLEN-1:0] op_b;

  modport master (
    output issue_req, src_a, src_b, dst,
    output wb_we, wb_addr, wb_data, flush,
    input  grant, op_valid, op_a, op_b
  );

  modport slave (
    input  issue_req, src_a, src_b, dst,
    input  wb_we, wb_addr, wb_data, flush,
    output grant, op_valid, op_a, op_b
  );

endinterface

// File: rtl/regfile_scoreboard_sb_grant.sv
// In-order prefix grant: a lane issues only if every older lane issues
// and it has no RAW/WAW hazard against busy regs or older lanes.
module sb_grant
  import pap_pkg::*;
#(
  parameter int LANES = 2,
  parameter int NREGS = 32,
  parameter int AW    = 5
) (
  input  logic [NREGS-1:0]    busy_eff,
  input  logic [LANES*AW-1:0] src_a,
  input  logic [LANES*AW-1:0] src_b,
  input  logic [LANES*AW-1:0] dst,
  input  logic [LANES-1:0]    issue_req,
  input  logic                flush,
  output logic [LANES-1:0]    grant
);

  always_comb begin
    logic          ok;
    logic [AW-1:0] a;
    logic [AW-1:0] b;
    logic [AW-1:0] d;
    logic [AW-1:0] dj;
    grant = '0;
    ok    = ~flush;
    a     = '0;
    b     = '0;
    d     = '0;
    dj    = '0;
    for (int i = 0; i < LANES; i++) begin
      a  = AW'(lane_slice(256'(src_a), i, AW));
      b  = AW'(lane_slice(256'(src_b), i, AW));
      d  = AW'(lane_slice(256'(dst), i, AW));
      ok = ok & issue_req[i]
         & ~busy_eff[a] & ~busy_eff[b] & ~busy_eff[d];
      for (int j = 0; j < i; j++) begin
        dj = AW'(lane_slice(256'(dst), j, AW));
        if (dj != '0 && (a == dj || b == dj || d == dj))
          ok = 1'b0;
      end
      grant[i] = ok;
    end
  end

endmodule

// File: rtl/regfile_scoreboard.sv
// N-lane register file with busy-bit scoreboard, writeback bypass,
// registered operand outputs and a saturating issue-stall counter.
module regfile_scoreboard
  import pap_pkg::*;
#(
  parameter int XLEN  = XLEN_D,
  parameter int NREGS = NREGS_D,
  parameter int LANES = 2,
  parameter int SCW   = 16
) (
  input  logic                clk,
  input  logic                rs,
  regfile_scoreboard_if.slave bus,
  output logic [SCW-1:0]      stall_cnt
);

  localparam int AW = $clog2(NREGS);

  logic [XLEN-1:0]  regs [NREGS];
  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] wb_clr;
  logic [NREGS-1:0] bsy_set;
  logic [LANES-1:0] grant;

  logic [AW-1:0]   sa    [LANES];
  logic [AW-1:0]   srb   [LANES];
  logic [AW-1:0]   ds    [LANES];
  logic [AW-1:0]   wa    [LANES];
  logic [XLEN-1:0] wd    [LANES];
  logic [XLEN-1:0] opa_n [LANES];
  logic [XLEN-1:0] opb_n [LANES];

  logic stall;

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      sa[i]  = AW'(lane_slice(256'(bus.src_a), i, AW));
      srb[i] = AW'(lane_slice(256'(bus.src_b), i, AW));
      ds[i]  = AW'(lane_slice(256'(bus.dst), i, AW));
      wa[i]  = AW'(lane_slice(256'(bus.wb_addr), i, AW));
      wd[i]  = XLEN'(lane_slice(256'(bus.wb_data), i, XLEN));
    end
  end

  always_comb begin
    wb_clr  = '0;
    bsy_set = '0;
    for (int i = 0; i < LANES; i++) begin
      if (bus.wb_we[i] && wa[i] != '0)
        wb_clr[wa[i]] = 1'b1;
      if (grant[i] && ds[i] != '0)
        bsy_set[ds[i]] = 1'b1;
    end
  end

  // Reset also kills grants, so it rides on the flush input.
  sb_grant #(
    .LANES (LANES),
    .NREGS (NREGS),
    .AW    (AW)
  ) u_grant (
    .busy_eff  (busy & ~wb_clr),
    .src_a     (bus.src_a),
    .src_b     (bus.src_b),
    .dst       (bus.dst),
    .issue_req (bus.issue_req),
    .flush     (bus.flush | rs),
    .grant     (grant)
  );

  assign bus.grant = grant;

  // Later lanes override earlier ones: youngest writeback wins.
  function automatic logic [XLEN-1:0] rd_byp(
    input logic [AW-1:0] r
  );
    logic [XLEN-1:0] v;
    v = regs[r];
    for (int k = 0; k < LANES; k++)
      if (bus.wb_we[k] && wa[k] == r)
        v = wd[k];
    if (r == '0)
      v = '0;
    return v;
  endfunction

  always_comb begin
    for (int i = 0; i < LANES; i++) begin
      opa_n[i] = rd_byp(sa[i]);
      opb_n[i] = rd_byp(srb[i]);
    end
  end

  assign stall = bus.issue_req[0] & ~grant[0] & ~bus.flush;

  always_ff @(posedge clk or posedge rs) begin
    if (rs) begin
      for (int r = 0; r < NREGS; r++)
        regs[r] <= '0;
      busy         <= '0;
      bus.op_valid <= '0;
      bus.op_a     <= '0;
      bus.op_b     <= '0;
      stall_cnt    <= '0;
    end else begin
      for (int i = 0; i < LANES; i++)
        if (bus.wb_we[i] && wa[i] != '0)
          regs[wa[i]] <= wd[i];
      // Set after clear: a new producer beats a same-cycle writeback.
      if (bus.flush)
        busy <= '0;
      else
        busy <= (busy & ~wb_clr) | bsy_set;
      bus.op_valid <= grant;
      for (int i = 0; i < LANES; i++) begin
        if (grant[i]) begin
          bus.op_a[i*XLEN +: XLEN] <= opa_n[i];
          bus.op_b[i*XLEN +: XLEN] <= opb_n[i];
        end
      end
      if (stall && stall_cnt != '1)
        stall_cnt <= stall_cnt + SCW'(1);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed bench for regfile_scoreboard: 2-lane main instance plus a
// 4-lane instance with a narrow stall counter.
module tb_regfile_scoreboard;

  logic        clk;
  logic        rs;
  logic [15:0] st2;
  logic [3:0]  st4;
  int          nchk;
  int          nfail;

  regfile_scoreboard_if #(.LANES(2), .XLEN(32), .AW(5)) if2 ();
  regfile_scoreboard_if #(.LANES(4), .XLEN(32), .AW(5)) if4 ();

  regfile_scoreboard #(.LANES(2), .SCW(16)) u2 (
    .clk       (clk),
    .rs        (rs),
    .bus       (if2),
    .stall_cnt (st2)
  );

  regfile_scoreboard #(.LANES(4), .SCW(4)) u4 (
    .clk       (clk),
    .rs        (rs),
    .bus       (if4),
    .stall_cnt (st4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    nchk++;
    assert (got === exp)
    else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle2();
    if2.issue_req = '0;
    if2.src_a     = '0;
    if2.src_b     = '0;
    if2.dst       = '0;
    if2.wb_we     = '0;
    if2.wb_addr   = '0;
    if2.wb_data   = '0;
    if2.flush     = 1'b0;
  endtask

  task automatic idle4();
    if4.issue_req = '0;
    if4.src_a     = '0;
    if4.src_b     = '0;
    if4.dst       = '0;
    if4.wb_we     = '0;
    if4.wb_addr   = '0;
    if4.wb_data   = '0;
    if4.flush     = 1'b0;
  endtask

  task automatic iss2(input int l, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d);
    if2.issue_req[l]   = 1'b1;
    if2.src_a[l*5 +: 5] = a;
    if2.src_b[l*5 +: 5] = b;
    if2.dst[l*5 +: 5]   = d;
  endtask

  task automatic wb2(input int l, input logic [4:0] a,
                     input logic [31:0] v);
    if2.wb_we[l]           = 1'b1;
    if2.wb_addr[l*5 +: 5]  = a;
    if2.wb_data[l*32 +: 32] = v;
  endtask

  task automatic iss4(input int l, input logic [4:0] a,
                      input logic [4:0] b, input logic [4:0] d);
    if4.issue_req[l]   = 1'b1;
    if4.src_a[l*5 +: 5] = a;
    if4.src_b[l*5 +: 5] = b;
    if4.dst[l*5 +: 5]   = d;
  endtask

  initial begin
    nchk  = 0;
    nfail = 0;
    rs    = 1'b1;
    idle2();
    idle4();
    iss2(0, 5'd1, 5'd2, 5'd3);
    iss2(1, 5'd4, 5'd5, 5'd6);
    #1;
    chk("rst_grant", 64'(if2.grant), 64'h0);
    chk("rst_opv", 64'(if2.op_valid), 64'h0);
    chk("rst_stall", 64'(st2), 64'h0);
    tick();
    tick();
    rs = 1'b0;

    // Dual write to r7 and a write to r0, then read them back.
    idle2();
    wb2(0, 5'd7, 32'h11);
    wb2(1, 5'd7, 32'h22);
    tick();
    idle2();
    wb2(0, 5'd0, 32'hFFFF_FFFF);
    wb2(1, 5'd1, 32'h1111_0001);
    tick();
    idle2();
    wb2(0, 5'd2, 32'h2222_0002);
    iss2(0, 5'd7, 5'd0, 5'd4);
    iss2(1, 5'd1, 5'd2, 5'd5);
    #1;
    chk("indep_grant", 64'(if2.grant), 64'h3);
    tick();
    chk("indep_opv", 64'(if2.op_valid), 64'h3);
    chk("r7_r1_opa", 64'(if2.op_a), 64'h1111_0001_0000_0022);
    chk("r0_byp_opb", 64'(if2.op_b), 64'h2222_0002_0000_0000);

    // Mid-run reset with r4/r5 busy and op_valid high.
    idle2();
    iss2(0, 5'd4, 5'd5, 5'd6);
    iss2(1, 5'd7, 5'd1, 5'd8);
    #1;
    rs = 1'b1;
    #1;
    chk("mid_rst_grant", 64'(if2.grant), 64'h0);
    chk("mid_rst_opv", 64'(if2.op_valid), 64'h0);
    chk("mid_rst_opa", 64'(if2.op_a), 64'h0);
    chk("mid_rst_opb", 64'(if2.op_b), 64'h0);
    #1;
    rs = 1'b0;
    #1;
    chk("post_rst_grant", 64'(if2.grant), 64'h3);
    tick();
    chk("post_rst_opv", 64'(if2.op_valid), 64'h3);
    chk("post_rst_opa", 64'(if2.op_a), 64'h0);

    idle2();
    wb2(0, 5'd6, 32'h66);
    wb2(1, 5'd8, 32'h88);
    tick();

    // Intra-group RAW, then retry blocked until r3 writes back.
    idle2();
    iss2(0, 5'd1, 5'd2, 5'd3);
    iss2(1, 5'd3, 5'd0, 5'd9);
    #1;
    chk("intra_raw_grant", 64'(if2.grant), 64'h1);
    tick();
    chk("intra_raw_opv", 64'(if2.op_valid), 64'h1);
    idle2();
    iss2(0, 5'd3, 5'd0, 5'd9);
    #1;
    chk("retry_blk_grant", 64'(if2.grant), 64'h0);
    tick();
    chk("stall_1", 64'(st2), 64'h1);
    tick();
    chk("stall_2", 64'(st2), 64'h2);
    wb2(1, 5'd3, 32'h3333);
    #1;
    chk("retry_wb_grant", 64'(if2.grant), 64'h1);
    tick();
    chk("retry_opa", 64'(if2.op_a), 64'h0000_0000_0000_3333);
    chk("retry_opv", 64'(if2.op_valid), 64'h1);
    chk("stall_hold", 64'(st2), 64'h2);

    // Busy r5 cleared by a same-cycle writeback, bypassed to op_a.
    idle2();
    iss2(0, 5'd0, 5'd0, 5'd5);
    tick();
    idle2();
    wb2(0, 5'd5, 32'hDEAD_BEEF);
    iss2(0, 5'd5, 5'd6, 5'd0);
    #1;
    chk("byp_grant", 64'(if2.grant), 64'h1);
    tick();
    chk("byp_opa", 64'(if2.op_a), 64'h0000_0000_DEAD_BEEF);
    chk("byp_opb", 64'(if2.op_b), 64'h0000_0000_0000_0066);
    idle2();
    iss2(0, 5'd5, 5'd0, 5'd0);
    iss2(1, 5'd5, 5'd5, 5'd0);
    #1;
    chk("r5_free_grant", 64'(if2.grant), 64'h3);
    tick();
    chk("r5_read_opa", 64'(if2.op_a), 64'hDEAD_BEEF_DEAD_BEEF);

    // Same-cycle set and clear of r9: the set wins.
    idle2();
    wb2(0, 5'd9, 32'h99);
    iss2(0, 5'd0, 5'd0, 5'd9);
    #1;
    chk("setclr_grant", 64'(if2.grant), 64'h1);
    tick();
    idle2();
    iss2(0, 5'd9, 5'd0, 5'd0);
    #1;
    chk("set_wins_grant", 64'(if2.grant), 64'h0);
    tick();
    chk("stall_3", 64'(st2), 64'h3);
    wb2(1, 5'd9, 32'h9999);
    #1;
    chk("r9_wb_grant", 64'(if2.grant), 64'h1);
    tick();
    chk("r9_byp_opa", 64'(if2.op_a), 64'hDEAD_BEEF_0000_9999);

    // Flush with r1/r2 busy.
    idle2();
    iss2(0, 5'd0, 5'd0, 5'd1);
    iss2(1, 5'd0, 5'd0, 5'd2);
    tick();
    idle2();
    if2.flush = 1'b1;
    iss2(0, 5'd1, 5'd0, 5'd3);
    iss2(1, 5'd4, 5'd0, 5'd5);
    wb2(0, 5'd11, 32'hBB);
    #1;
    chk("flush_grant", 64'(if2.grant), 64'h0);
    tick();
    chk("flush_opv", 64'(if2.op_valid), 64'h0);
    chk("flush_nostall", 64'(st2), 64'h3);
    idle2();
    iss2(0, 5'd1, 5'd11, 5'd2);
    iss2(1, 5'd11, 5'd0, 5'd12);
    #1;
    chk("post_flush_grant", 64'(if2.grant), 64'h3);
    tick();
    chk("flush_wb_opa", 64'(if2.op_a), 64'h0000_00BB_0000_0000);
    chk("flush_wb_opb", 64'(if2.op_b), 64'h0000_0000_0000_00BB);
    idle2();

    // Four lanes: hazard in lane 2, then saturate the 4-bit counter.
    idle4();
    iss4(0, 5'd0, 5'd0, 5'd3);
    iss4(1, 5'd0, 5'd0, 5'd4);
    iss4(2, 5'd3, 5'd0, 5'd6);
    iss4(3, 5'd0, 5'd0, 5'd7);
    #1;
    chk("l4_grant", 64'(if4.grant), 64'h3);
    tick();
    chk("l4_opv", 64'(if4.op_valid), 64'h3);
    idle4();
    iss4(0, 5'd3, 5'd0, 5'd0);
    #1;
    chk("l4_blk_grant", 64'(if4.grant), 64'h0);
    repeat (10) tick();
    chk("l4_stall_10", 64'(st4), 64'hA);
    repeat (10) tick();
    chk("l4_stall_sat", 64'(st4), 64'hF);
    idle4();

    $display("%0d/%0d checks passed", nchk - nfail, nchk);
    $finish;
  end

endmodule
